// File: rtl/pu_riscv_wb_pkg.sv
// Shared core definitions for the writeback stage: load funct3 encodings
// and the writeback FSM state type.
package pu_riscv_wb_pkg;

   // Load funct3 encodings
   localparam logic [2:0] LD_LB  = 3'd0;
   localparam logic [2:0] LD_LH  = 3'd1;
   localparam logic [2:0] LD_LW  = 3'd2;
   localparam logic [2:0] LD_LD  = 3'd3;
   localparam logic [2:0] LD_LBU = 3'd4;
   localparam logic [2:0] LD_LHU = 3'd5;
   localparam logic [2:0] LD_LWU = 3'd6;

   // Writeback FSM states
   typedef enum logic {
      WB_IDLE,
      WB_LOAD_WAIT
   } wb_state_t;

endpackage

// File: rtl/pu_riscv_wb_ldext.sv
// Load data extraction and sign/zero extension from a naturally aligned
// memory read word.
import pu_riscv_wb_pkg::*;

module pu_riscv_wb_ldext #(
   parameter int XLEN = 64
) (
   input  logic [2:0]      size,
   input  logic [2:0]      addr_lsb,
   input  logic [XLEN-1:0] q,
   output logic [XLEN-1:0] val,
   output logic            err
);

   logic [2:0]      off;
   logic [XLEN-1:0] sh;

   // Byte offset of the access; address bits below the access size are dropped
   always_comb begin
      off = '0;
      case (size)
         LD_LB, LD_LBU: off = addr_lsb;
         LD_LH, LD_LHU: off = {addr_lsb[2:1], 1'b0};
         LD_LW, LD_LWU: off = {addr_lsb[2], 2'b00};
         default:       off = '0;
      endcase
      if (XLEN == 32) off[2] = 1'b0;
   end

   assign sh = q >> {off, 3'b000};

   // Extend the selected field to XLEN; 64-bit-only loads fault on RV32
   always_comb begin
      val = '0;
      err = 1'b0;
      case (size)
         LD_LB:  val = XLEN'($signed(sh[7:0]));
         LD_LH:  val = XLEN'($signed(sh[15:0]));
         LD_LW:  val = XLEN'($signed(sh[31:0]));
         LD_LBU: val = XLEN'(sh[7:0]);
         LD_LHU: val = XLEN'(sh[15:0]);
         LD_LWU: begin
            val = XLEN'(sh[31:0]);
            err = (XLEN == 32);
         end
         LD_LD: begin
            val = q;
            err = (XLEN == 32);
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/pu_riscv_wb.sv
// RISC-V writeback stage: retires ALU/CSR results and loads into the
// register file, reports faulting instructions and counts retirements.
import pu_riscv_wb_pkg::*;

module pu_riscv_wb #(
   parameter int XLEN    = 64,
   parameter int AR_BITS = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_valid,
   output logic               mem_ready,
   input  logic [AR_BITS-1:0] mem_rd,
   input  logic [XLEN-1:0]    mem_r,
   input  logic               mem_is_load,
   input  logic [2:0]         mem_ld_size,
   input  logic [2:0]         mem_addr_lsb,
   input  logic               mem_exception,
   input  logic               dmem_ack,
   input  logic [XLEN-1:0]    dmem_q,
   input  logic               dmem_err,
   input  logic               du_stall,
   output logic [AR_BITS-1:0] rf_dst,
   output logic [XLEN-1:0]    rf_dstv,
   output logic               rf_we,
   output logic               wb_exception,
   output logic [63:0]        wb_retired
);

   wb_state_t          state;
   logic [AR_BITS-1:0] ld_rd;
   logic [2:0]         ld_size;
   logic [2:0]         ld_lsb;
   logic [XLEN-1:0]    ld_val;
   logic               ld_err;
   logic               accept;

   assign mem_ready = (state == WB_IDLE) & ~du_stall;
   assign accept    = mem_valid & mem_ready;

   pu_riscv_wb_ldext #(
      .XLEN(XLEN)
   ) u_ldext (
      .size     (ld_size),
      .addr_lsb (ld_lsb),
      .q        (dmem_q),
      .val      (ld_val),
      .err      (ld_err)
   );

   // Writeback FSM with registered register-file port, fault pulse and retire count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= WB_IDLE;
         rf_we        <= 1'b0;
         rf_dst       <= '0;
         rf_dstv      <= '0;
         wb_exception <= 1'b0;
         wb_retired   <= '0;
         ld_rd        <= '0;
         ld_size      <= '0;
         ld_lsb       <= '0;
      end else begin
         rf_we        <= 1'b0;
         wb_exception <= 1'b0;
         case (state)
            WB_IDLE: begin
               if (accept) begin
                  if (mem_exception) begin
                     wb_exception <= 1'b1;
                  end else if (mem_is_load) begin
                     state   <= WB_LOAD_WAIT;
                     ld_rd   <= mem_rd;
                     ld_size <= mem_ld_size;
                     ld_lsb  <= mem_addr_lsb;
                  end else begin
                     // x0 writes are dropped but the instruction still retires
                     if (mem_rd != '0) begin
                        rf_we   <= 1'b1;
                        rf_dst  <= mem_rd;
                        rf_dstv <= mem_r;
                     end
                     wb_retired <= wb_retired + 64'd1;
                  end
               end
            end
            WB_LOAD_WAIT: begin
               if (dmem_ack) begin
                  state <= WB_IDLE;
                  if (dmem_err | ld_err) begin
                     wb_exception <= 1'b1;
                  end else begin
                     if (ld_rd != '0) begin
                        rf_we   <= 1'b1;
                        rf_dst  <= ld_rd;
                        rf_dstv <= ld_val;
                     end
                     wb_retired <= wb_retired + 64'd1;
                  end
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pu_riscv_wb.md
PU_RISCV_WB -- requirements
Module: pu_riscv_wb

Interface
REQ-001 Parameter XLEN, 64, datapath width; legal values 32 and 64.
REQ-002 Parameter AR_BITS, 5, register address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high. Design constraint: one clock; reset is asynchronous and active-high.
REQ-005 mem_valid  in  1  memory stage presents a retiring instruction.
REQ-006 mem_ready  out  1  writeback accepts the instruction this cycle.
REQ-007 mem_rd  in  AR_BITS  destination register.
REQ-008 mem_r  in  XLEN  ALU/CSR result for non-load instructions.
REQ-009 mem_is_load  in  1  instruction is a load.
REQ-010 mem_ld_size  in  3  load funct3: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU.
REQ-011 mem_addr_lsb  in  3  low bits of the load effective address.
REQ-012 mem_exception  in  1  instruction carries an exception; it must not write.
REQ-013 dmem_ack  in  1  data-memory read response valid.
REQ-014 dmem_q  in  XLEN  data-memory read word, naturally aligned.
REQ-015 dmem_err  in  1  bus error; qualified by dmem_ack.
REQ-016 du_stall  in  1  debug unit halts acceptance of new instructions.
REQ-017 rf_dst  out  AR_BITS; rf_dstv  out  XLEN; rf_we  out  1. Register-file write port.
REQ-018 wb_exception  out  1  one-cycle pulse when an accepted instruction faults.
REQ-019 wb_retired  out  64  count of instructions retired without exception.

Function
REQ-020 FSM states: IDLE and LOAD_WAIT.
REQ-021 In IDLE, mem_ready = ~du_stall. In LOAD_WAIT, mem_ready = 0.
REQ-022 Accept occurs when mem_valid & mem_ready.
REQ-023 Accepted non-load, no exception: on the next cycle rf_we=1 for one cycle, with rf_dst=mem_rd and rf_dstv=mem_r. FSM stays in IDLE.
REQ-024 Accepted load, no exception: the FSM enters LOAD_WAIT and latches rd, size, and addr_lsb.
REQ-025 In LOAD_WAIT with dmem_ack & ~dmem_err: on the next cycle, rf_we=1 with the extracted value, and the FSM returns to IDLE.
REQ-026 Load extraction offsets: byte = addr_lsb; half = addr_lsb[2:1]*16; word = addr_lsb[2]*32. Address bits below the access size are ignored.
REQ-027 Sign/zero extension: LB, LH, LW sign-extend to XLEN; LBU, LHU, LWU zero-extend; LD passes dmem_q through.
REQ-028 XLEN=32 rules: addr_lsb[2] is ignored. LD or LWU is treated as an error: wb_exception pulse, no write.
REQ-029 dmem_ack & dmem_err in LOAD_WAIT: no write, wb_exception pulses next cycle, FSM returns to IDLE.
REQ-030 Accepted instruction with mem_exception=1: no write, wb_exception pulses next cycle, FSM stays in IDLE.
REQ-031 Destination x0: rf_we is suppressed. The instruction still counts as retired.
REQ-032 wb_retired increments by 1 in the cycle in which a non-faulting instruction completes its write slot. It wraps modulo 2^64.
REQ-033 du_stall raised during LOAD_WAIT does not block the pending load from completing.
REQ-034 dmem_ack in IDLE is ignored.
REQ-035 rf_we is a single-cycle pulse. rf_dst and rf_dstv hold their last values when rf_we=0.
REQ-036 Back-to-back non-loads sustain one write per cycle.
REQ-037 Load throughput: a load blocks acceptance until one cycle after its ack.

Reset
REQ-038 While rst=1: FSM=IDLE, rf_we=0, rf_dst=0, rf_dstv=0, wb_exception=0, wb_retired=0, and latched load fields=0.
REQ-039 Reset asserted during LOAD_WAIT abandons the load. A subsequent late dmem_ack is ignored.
REQ-040 mem_ready follows REQ-021 from IDLE immediately after rst deasserts.

Structure
REQ-041 The load-size encodings (REQ-010) and the FSM state enum belong in the shared core package.
REQ-042 Load extraction/extension is one combinational sub-module, pu_riscv_wb_ldext, parameterised by XLEN.

Verification
REQ-043 Non-load with rd=5 and r=0x1234 accepted at cycle N -> rf_we=1, rf_dst=5, rf_dstv=0x1234 at N+1; wb_retired=1.
REQ-044 LB, addr_lsb=3, dmem_q=0x00000000_80FF0000 (byte3=0x80) -> rf_dstv=0xFFFFFFFF_FFFFFF80. Repeat with LBU -> 0x80.
REQ-045 LW, addr_lsb=4, dmem_q=0x89ABCDEF_00000000 -> 0xFFFFFFFF_89ABCDEF. Check mem_ready=0 during the wait, with 3 wait cycles before the ack.
REQ-046 Load ack with dmem_err=1 -> no rf_we, one wb_exception pulse, wb_retired unchanged.
REQ-047 rd=0 non-load -> rf_we stays 0 and wb_retired increments. mem_exception=1 -> no write, wb_exception pulse.
REQ-048 Assert rst during LOAD_WAIT, then deliver dmem_ack after release -> no write, all outputs at reset values, mem_ready=1.
